vr_rr_arbiter: RTL and testbench
================================

// Module: vr_rr_arbiter
// PURPOSE
//  Shares one valid/ready downstream channel between NUM_REQ valid/ready upstream requesters.
//  Uses round-robin arbitration with packet lock: once a requester wins, it owns the channel
//  until its last beat is accepted. Output is a registered pipeline stage: 1-cycle latency,
//  full throughput (1 beat/cycle). Sits in front of a chain of valid/ready pipeline nodes,
//  merging multiple sources into it.
// PARAMETERS
//  NUM_REQ  4   number of upstream requesters (>=2)
//  WIDTH    32  data bits per beat
//  ID_W     $clog2(NUM_REQ)  width of source id (derived localparam, not overridable)
// PORTS
//  clk            in   1              single clock, all logic on posedge
//  rst            in   1              synchronous reset, active-high
//  req_data_in    in   NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  req_last_in    in   NUM_REQ        requester i: current beat is last of packet
//  req_valid_in   in   NUM_REQ        requester i valid
//  req_ready_out  out  NUM_REQ        requester i ready (at most one bit set)
//  data_out       out  WIDTH          downstream data
//  last_out       out  1              downstream last-beat flag
//  id_out         out  ID_W           index of requester that sourced the beat
//  dn_valid_out   out  1              downstream valid
//  dn_ready_in    in   1              downstream ready
// BEHAVIOUR
//  Reset (rst=1 at posedge): dn_valid_out=0, data_out=0, last_out=0, id_out=0, state=IDLE,
//   rr_ptr=0. req_ready_out is combinational and is 0 while dn_valid_out=0 and no valid input.
//  Definitions: out_free = !dn_valid_out | dn_ready_in; dn_fire = dn_valid_out & dn_ready_in.
//  States: IDLE (no owner), LOCKED (owner = lock_id).
//  Grant select (combinational):
//   - IDLE: grant = first i with req_valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ...
//     wrapping modulo NUM_REQ; no grant if all valids are 0.
//   - LOCKED: grant = lock_id, regardless of the other valids.
//  req_ready_out[i] = (grant exists) & (i == grant) & out_free. All other bits are 0.
//   In LOCKED, owner ready may be 1 while its valid is 0; this is legal and no beat moves.
//   Ready must never depend on the granted requester's own valid in LOCKED (no comb loop).
//  Accept = req_valid_in[grant] & req_ready_out[grant].
//   On accept: data_out<=req_data[grant], last_out<=req_last_in[grant], id_out<=grant,
//   dn_valid_out<=1.
//  If no accept and dn_fire: dn_valid_out<=0. data_out, last_out and id_out hold their values.
//  If no accept and no dn_fire: all outputs hold (stall; output stable while valid & !ready).
//  State transitions:
//   - IDLE, accept, last=0: go to LOCKED with lock_id<=grant.
//   - IDLE, accept, last=1: stay IDLE with rr_ptr<=(grant+1) mod NUM_REQ.
//   - LOCKED, accept, last=1: go to IDLE with rr_ptr<=(lock_id+1) mod NUM_REQ.
//   - LOCKED, otherwise: stay LOCKED.
//  rr_ptr changes only on an accepted last beat. A requester dropping valid mid-packet
//   keeps the lock, so single-beat and multi-beat packets are never interleaved.
//  Simultaneous dn_fire and accept in the same cycle: the new beat replaces the old beat;
//   dn_valid_out stays 1. This is the full-throughput case.
//  Wrap: rr_ptr and the grant scan wrap NUM_REQ-1 -> 0. A non-power-of-2 NUM_REQ must never
//   produce an id >= NUM_REQ.
//  Reset mid-packet: the lock and any pending output beat are discarded. After reset the
//   next grant starts the scan from requester 0.
//  No X propagation: data_out only loads on accept.
// TESTING
//  1. Reset, then drive req_valid=4'b0000 -> req_ready=0, dn_valid_out=0 on every cycle.
//  2. All 4 requesters valid, single-beat (last=1), data=i, dn_ready=1 -> id_out sequence
//     0,1,2,3,0,..., with one beat per cycle and dn_valid_out first high 1 cycle after valid.
//  3. Req1 sends a 3-beat packet (A,B,C) while req2 is valid throughout -> downstream receives
//     A,B,C with id=1, then req2's beat; req2 ready stays 0 until C is accepted.
//  4. Req0 mid-packet drops valid for 2 cycles with req3 valid -> no beat from req3 appears;
//     req0 resumes and completes its packet; req3 is granted next.
//  5. dn_ready=0 for 5 cycles holding beat 0xDEAD -> data_out, id_out and last_out stable;
//     all req_ready=0; beat delivered exactly once when dn_ready returns to 1.
//  6. Assert rst while LOCKED to req2 with dn_valid_out=1 -> next cycle dn_valid_out=0,
//     state=IDLE; with all valid afterwards, first grant is requester 0.

Source files
------------

// File: rtl/vr_rr_arbiter.sv
// rtl/vr_rr_arbiter.sv - round-robin valid/ready arbiter with packet lock and registered output
//
// Merges NUM_REQ valid/ready requesters onto one registered valid/ready output.
// A requester that wins keeps the channel until its last beat is accepted.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous reset, active-high
//   req_data_in    requester i data at [i*WIDTH +: WIDTH]
//   req_last_in    per-requester last-beat flag
//   req_valid_in   per-requester valid
//   req_ready_out  per-requester ready, at most one bit set
//   data_out       downstream data (registered)
//   last_out       downstream last-beat flag (registered)
//   id_out         index of the requester that sourced the current beat
//   dn_valid_out   downstream valid (registered)
//   dn_ready_in    downstream ready
module vr_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]       req_last_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     last_out,
    output logic [ID_W-1:0]          id_out,
    output logic                     dn_valid_out,
    input  logic                     dn_ready_in
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   lock_id;
    logic [ID_W-1:0]   rr_ptr;

    logic              grant_vld;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   next_ptr;
    logic [WIDTH-1:0]  grant_data;
    logic              grant_last;
    logic              grant_valid;
    logic              out_free;
    logic              dn_fire;
    logic              accept;

    assign out_free = !dn_valid_out || dn_ready_in;
    assign dn_fire  = dn_valid_out && dn_ready_in;

    // Grant: the owner while locked; otherwise the first valid requester
    // scanning upward from rr_ptr with wrap. The index is reduced modulo
    // NUM_REQ before use, so a non-power-of-2 count never yields id >= NUM_REQ.
    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_id;
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        idx_id    = '0;
        if (state == LOCKED) begin
            grant_vld = 1'b1;
            grant     = lock_id;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                idx_id = ID_W'(idx);
                if (!grant_vld && req_valid_in[idx_id]) begin
                    grant_vld = 1'b1;
                    grant     = idx_id;
                end
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        grant_data  = '0;
        grant_last  = 1'b0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == ID_W'(k)) begin
                grant_data  = req_data_in[k*WIDTH +: WIDTH];
                grant_last  = req_last_in[k];
                grant_valid = req_valid_in[k];
            end
        end
    end

    // Ready depends only on the grant and output space, never on the
    // owner's own valid, so no combinational loop through the requester.
    always_comb begin
        req_ready_out = '0;
        if (grant_vld && out_free) begin
            req_ready_out[grant] = 1'b1;
        end
    end

    assign accept   = grant_vld && out_free && grant_valid;
    assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lock_id      <= '0;
            rr_ptr       <= '0;
            dn_valid_out <= 1'b0;
            data_out     <= '0;
            last_out     <= 1'b0;
            id_out       <= '0;
        end else begin
            // A new beat overwrites the register even when the old one fires
            // in the same cycle; that is what sustains one beat per cycle.
            if (accept) begin
                data_out     <= grant_data;
                last_out     <= grant_last;
                id_out       <= grant;
                dn_valid_out <= 1'b1;
            end else if (dn_fire) begin
                dn_valid_out <= 1'b0;
            end

            // rr_ptr moves only when a packet completes.
            if (state == IDLE) begin
                if (accept) begin
                    if (grant_last) begin
                        rr_ptr <= next_ptr;
                    end else begin
                        state   <= LOCKED;
                        lock_id <= grant;
                    end
                end
            end else begin
                if (accept && grant_last) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// tb/tb_vr_rr_arbiter.sv - scoreboard testbench for vr_rr_arbiter
module tb_vr_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] req_data_in;
    logic [3:0]   req_last_in;
    logic [3:0]   req_valid_in;
    logic [3:0]   req_ready_out;
    logic [31:0]  data_out;
    logic         last_out;
    logic [1:0]   id_out;
    logic         dn_valid_out;
    logic         dn_ready_in;

    logic [32:0]  rq [4][$];   // per-requester pending beats {last, data}
    logic [3:0]   en;          // per-requester valid enable
    logic [34:0]  exp_q [$];   // expected downstream beats {data, last, id}
    int           checks = 0;
    int           errors = 0;

    vr_rr_arbiter #(.NUM_REQ(4), .WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data_in   (req_data_in),
        .req_last_in   (req_last_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .data_out      (data_out),
        .last_out      (last_out),
        .id_out        (id_out),
        .dn_valid_out  (dn_valid_out),
        .dn_ready_in   (dn_ready_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic l, input logic [1:0] id);
        exp_q.push_back({d, l, id});
    endtask

    task automatic apply();
        logic [32:0] b;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && rq[i].size() > 0) begin
                b = rq[i][0];
                req_valid_in[i]          = 1'b1;
                req_last_in[i]           = b[32];
                req_data_in[i*32 +: 32]  = b[31:0];
            end else begin
                req_valid_in[i]          = 1'b0;
                req_last_in[i]           = 1'b0;
                req_data_in[i*32 +: 32]  = '0;
            end
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One clock: check ready mid-cycle, then retire handshaken beats.
    task automatic step(input bit ce, input logic [3:0] er, input string nm);
        logic [3:0]  fired;
        logic [32:0] b;
        @(negedge clk);
        if (ce) chk(nm, req_ready_out, er);
        fired = req_valid_in & req_ready_out;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fired[i] && rq[i].size() > 0) b = rq[i].pop_front();
        end
        apply();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step(1'b0, 4'h0, "none");
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) rq[i].delete();
    endtask

    // Monitor: pops the scoreboard on every downstream handshake and checks
    // that a stalled beat stays put.
    initial begin
        logic        prev_stall;
        logic [34:0] prev_out;
        logic [34:0] act;
        logic [34:0] e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                act = {data_out, last_out, id_out};
                if (prev_stall) chk("stall_hold", {dn_valid_out, act}, {1'b1, prev_out});
                if (dn_valid_out && dn_ready_in) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat: got unexpected beat %0h, expected none", act);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", act, e);
                    end
                end
                prev_stall = dn_valid_out && !dn_ready_in;
                prev_out   = act;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        en          = 4'h0;
        dn_ready_in = 1'b1;
        apply();

        // 1: reset values, idle with no valids
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dn_valid", dn_valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_id", id_out, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t1_ready", req_ready_out, 0);
            chk("t1_dn_valid", dn_valid_out, 0);
        end

        // 2: four single-beat requesters rotate 0,1,2,3,0,1,2,3
        sync();
        en = 4'hF;
        for (int i = 0; i < 4; i++) begin
            rq[i].push_back({1'b1, 32'(i)});
            rq[i].push_back({1'b1, 32'(i + 16)});
        end
        for (int k = 0; k < 8; k++) push_exp((k < 4) ? 32'(k) : 32'(k + 12), 1'b1, 2'(k % 4));
        apply();
        chk("t2_valid_pre", dn_valid_out, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'(1 << (k % 4)), "t2_ready");
            if (k == 0) chk("t2_valid_after1", dn_valid_out, 1);
        end
        drain();

        // 3: req1 three-beat packet holds off req2
        sync();
        rq[1].push_back({1'b0, 32'hA});
        rq[1].push_back({1'b0, 32'hB});
        rq[1].push_back({1'b1, 32'hC});
        rq[2].push_back({1'b1, 32'h22});
        push_exp(32'hA, 1'b0, 2'd1);
        push_exp(32'hB, 1'b0, 2'd1);
        push_exp(32'hC, 1'b1, 2'd1);
        push_exp(32'h22, 1'b1, 2'd2);
        apply();
        repeat (3) step(1'b1, 4'b0010, "t3_ready_lock");
        step(1'b1, 4'b0100, "t3_ready_next");
        drain();

        // 4: req0 drops valid mid-packet; req3 must wait for it
        sync();
        en = 4'b0001;
        rq[0].push_back({1'b0, 32'h100});
        rq[0].push_back({1'b0, 32'h101});
        rq[0].push_back({1'b1, 32'h102});
        rq[3].push_back({1'b1, 32'h33});
        push_exp(32'h100, 1'b0, 2'd0);
        push_exp(32'h101, 1'b0, 2'd0);
        push_exp(32'h102, 1'b1, 2'd0);
        push_exp(32'h33, 1'b1, 2'd3);
        apply();
        step(1'b1, 4'b0001, "t4_ready_first");
        en = 4'b1000;
        apply();
        step(1'b1, 4'b0001, "t4_ready_gap");
        step(1'b1, 4'b0001, "t4_ready_gap");
        en = 4'b1001;
        apply();
        step(1'b1, 4'b0001, "t4_ready_resume");
        step(1'b1, 4'b0001, "t4_ready_resume");
        step(1'b1, 4'b1000, "t4_ready_req3");
        drain();

        // 5: downstream stall for 5 cycles holding 0xDEAD
        sync();
        en          = 4'hF;
        dn_ready_in = 1'b0;
        rq[2].push_back({1'b1, 32'hDEAD});
        rq[3].push_back({1'b1, 32'h3333});
        push_exp(32'hDEAD, 1'b1, 2'd2);
        push_exp(32'h3333, 1'b1, 2'd3);
        apply();
        step(1'b1, 4'b0100, "t5_ready_accept");
        repeat (5) step(1'b1, 4'b0000, "t5_ready_stall");
        chk("t5_data_held", data_out, 32'hDEAD);
        chk("t5_id_held", id_out, 2);
        chk("t5_last_held", last_out, 1);
        dn_ready_in = 1'b1;
        step(1'b1, 4'b1000, "t5_ready_release");
        drain();

        // 6: reset while locked to req2 with a beat pending
        sync();
        en          = 4'b0100;
        dn_ready_in = 1'b0;
        rq[2].push_back({1'b0, 32'h20});
        rq[2].push_back({1'b0, 32'h21});
        rq[2].push_back({1'b1, 32'h22});
        apply();
        step(1'b1, 4'b0100, "t6_ready_lock");
        chk("t6_valid_before_rst", dn_valid_out, 1);
        rst = 1'b1;
        step(1'b0, 4'h0, "none");
        rst = 1'b0;
        flush();
        apply();
        chk("t6_valid_after_rst", dn_valid_out, 0);
        chk("t6_data_after_rst", data_out, 0);
        en          = 4'hF;
        dn_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rq[i].push_back({1'b1, 32'(i + 96)});
            push_exp(32'(i + 96), 1'b1, 2'(i));
        end
        apply();
        for (int k = 0; k < 4; k++) step(1'b1, 4'(1 << k), "t6_ready_after_rst");
        drain();

        chk("final_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
